// File: rtl/s2mm_pkg.sv
// Shared types and sizing helpers for the stream-to-matrix-memory loader.
package s2mm_pkg;

  typedef enum logic [1:0] {
    RECV_A = 2'd0,
    RECV_B = 2'd1,
    LOADED = 2'd2
  } state_e;

  localparam int DEF_M   = 8;
  localparam int DEF_N1  = 4;
  localparam int DEF_N2  = 4;
  localparam int DEF_D_W = 8;

  localparam int DEF_A_DEPTH = DEF_M * DEF_M / DEF_N1;
  localparam int DEF_B_DEPTH = DEF_M * DEF_M / DEF_N2;
  localparam int DEF_A_AW    = $clog2(DEF_A_DEPTH);
  localparam int DEF_B_AW    = $clog2(DEF_B_DEPTH);

endpackage

// File: rtl/s2mm_mem.sv
// Simple dual-port bank: port A writes, port B reads with one-cycle latency.
module mem
  import s2mm_pkg::*;
#(
  parameter int D_W   = DEF_D_W,
  parameter int DEPTH = DEF_B_DEPTH,
  parameter int AW    = DEF_B_AW
) (
  input  logic          clkA,
  input  logic          enA,
  input  logic          weA,
  input  logic [AW-1:0] addrA,
  input  logic [D_W-1:0] dinA,
  input  logic          clkB,
  input  logic          enB,
  input  logic [AW-1:0] addrB,
  output logic [D_W-1:0] doutB
);

  logic [D_W-1:0] ram_q [DEPTH];
  logic [D_W-1:0] dout_q;

  // Write port; storage is deliberately never reset.
  always_ff @(posedge clkA) begin
    if (enA && weA) begin
      ram_q[addrA] <= dinA;
    end
  end

  // Read port holds its last value while disabled.
  always_ff @(posedge clkB) begin
    if (enB) begin
      dout_q <= ram_q[addrB];
    end
  end

  assign doutB = dout_q;

endmodule

// File: rtl/s2mm.sv
// Receives two M x M matrices over AXI-Stream and scatters them into banked memories.
module s2mm
  import s2mm_pkg::*;
#(
  parameter int M   = DEF_M,
  parameter int N1  = DEF_N1,
  parameter int N2  = DEF_N2,
  parameter int D_W = DEF_D_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   s_axis_s2mm_tdata,
  input  logic [3:0]                    s_axis_s2mm_tkeep,
  input  logic                          s_axis_s2mm_tlast,
  input  logic                          s_axis_s2mm_tvalid,
  output logic                          s_axis_s2mm_tready,
  input  logic                          rd_en_A   [N1],
  input  logic [$clog2(M*M/N1)-1:0]     rd_addr_A [N1],
  output logic [D_W-1:0]                rd_data_A [N1],
  input  logic                          rd_en_B   [N2],
  input  logic [$clog2(M*M/N2)-1:0]     rd_addr_B [N2],
  output logic [D_W-1:0]                rd_data_B [N2],
  input  logic                          done_multiply,
  output logic                          start_multiply,
  output logic                          loaded,
  output logic                          err_tlast
);

  localparam int MM      = M * M;
  localparam int A_DEPTH = MM / N1;
  localparam int B_DEPTH = MM / N2;
  localparam int A_AW    = $clog2(A_DEPTH);
  localparam int B_AW    = $clog2(B_DEPTH);
  localparam int IDX_W   = $clog2(MM);
  localparam int CNT_W   = IDX_W + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tready_q, tready_d;
  logic             start_q, start_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;

  logic             acc_s;
  logic             last_a_s;
  logic             last_b_s;
  logic [IDX_W-1:0] idx_s;
  logic [D_W-1:0]   wdata_s;
  logic             unused_ok_s;

  assign acc_s       = s_axis_s2mm_tvalid & tready_q;
  assign idx_s       = cnt_q[IDX_W-1:0];
  assign last_a_s    = (cnt_q == CNT_W'(MM - 1));
  assign last_b_s    = (cnt_q == CNT_W'(2 * MM - 1));
  assign wdata_s     = s_axis_s2mm_tdata[D_W-1:0];
  assign unused_ok_s = ^{s_axis_s2mm_tkeep, s_axis_s2mm_tdata};

  // Next-state, beat counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    if (acc_s) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (s_axis_s2mm_tlast != last_b_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      RECV_A: begin
        if (acc_s && last_a_s) begin
          state_d = RECV_B;
        end else begin
          state_d = RECV_A;
        end
      end
      RECV_B: begin
        if (acc_s && last_b_s) begin
          state_d = LOADED;
        end else begin
          state_d = RECV_B;
        end
      end
      LOADED: begin
        if (done_multiply) begin
          state_d = RECV_A;
          cnt_d   = '0;
        end else begin
          state_d = LOADED;
        end
      end
      default: begin
        state_d = RECV_A;
        cnt_d   = '0;
      end
    endcase

    tready_d = (state_d != LOADED);
    loaded_d = (state_d == LOADED);
    start_d  = (state_d == LOADED) && (state_q != LOADED);
  end

  // Control registers; tready is purely a function of the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RECV_A;
      cnt_q    <= '0;
      tready_q <= 1'b1;
      start_q  <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tready_q <= tready_d;
      start_q  <= start_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign s_axis_s2mm_tready = tready_q;
  assign start_multiply     = start_q;
  assign loaded             = loaded_q;
  assign err_tlast          = err_q;

  // Bank select is the upper index bits; the in-bank address is the lower bits.
  for (genvar g = 0; g < N1; g++) begin : g_bank_a
    logic we_s;
    assign we_s = acc_s && (state_q == RECV_A) && ((idx_s >> A_AW) == IDX_W'(g));

    mem #(.D_W(D_W), .DEPTH(A_DEPTH), .AW(A_AW)) u_mem (
      .clkA  (clk),
      .enA   (we_s),
      .weA   (we_s),
      .addrA (idx_s[A_AW-1:0]),
      .dinA  (wdata_s),
      .clkB  (clk),
      .enB   (rd_en_A[g]),
      .addrB (rd_addr_A[g]),
      .doutB (rd_data_A[g])
    );
  end

  for (genvar g = 0; g < N2; g++) begin : g_bank_b
    logic we_s;
    assign we_s = acc_s && (state_q == RECV_B) && ((idx_s >> B_AW) == IDX_W'(g));

    mem #(.D_W(D_W), .DEPTH(B_DEPTH), .AW(B_AW)) u_mem (
      .clkA  (clk),
      .enA   (we_s),
      .weA   (we_s),
      .addrA (idx_s[B_AW-1:0]),
      .dinA  (wdata_s),
      .clkB  (clk),
      .enB   (rd_en_B[g]),
      .addrB (rd_addr_B[g]),
      .doutB (rd_data_B[g])
    );
  end

endmodule

// File: tb/tb_s2mm.sv
// Directed bench for s2mm at M=8, N1=N2=4, D_W=8.
module tb_s2mm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        rd_en_A   [4];
  logic [3:0]  rd_addr_A [4];
  logic [7:0]  rd_data_A [4];
  logic        rd_en_B   [4];
  logic [3:0]  rd_addr_B [4];
  logic [7:0]  rd_data_B [4];
  logic        done;
  logic        start;
  logic        loaded;
  logic        err;

  int nvec = 0;
  int nerr = 0;
  int acc_cnt = 0;
  int sm_cnt = 0;
  logic [7:0] rd;

  always #5 clk = ~clk;

  s2mm #(.M(8), .N1(4), .N2(4), .D_W(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_s2mm_tdata  (tdata),
    .s_axis_s2mm_tkeep  (tkeep),
    .s_axis_s2mm_tlast  (tlast),
    .s_axis_s2mm_tvalid (tvalid),
    .s_axis_s2mm_tready (tready),
    .rd_en_A            (rd_en_A),
    .rd_addr_A          (rd_addr_A),
    .rd_data_A          (rd_data_A),
    .rd_en_B            (rd_en_B),
    .rd_addr_B          (rd_addr_B),
    .rd_data_B          (rd_data_B),
    .done_multiply      (done),
    .start_multiply     (start),
    .loaded             (loaded),
    .err_tlast          (err)
  );

  always @(posedge clk) begin
    if (tvalid && tready) acc_cnt <= acc_cnt + 1;
    if (start) sm_cnt <= sm_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    tdata = d; tlast = l; tvalid = 1'b1;
    while (tready !== 1'b1 && guard < 20) begin
      step(1);
      guard++;
    end
    if (guard >= 20) chk("ready_wait", {31'd0, tready}, 32'd1);
    step(1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // mode 0: data = k; mode 1: data = 255 - k. Optional beat-0 override.
  task automatic send_stream(input int mode, input int gap, input int extra_last,
                             input int nbeats, input logic use_b0, input logic [31:0] b0);
    logic [31:0] d;
    for (int k = 0; k < nbeats; k++) begin
      d = (mode == 0) ? 32'(k) : 32'(255 - k);
      if (k == 0 && use_b0) d = b0;
      send_beat(d, (k == 127) || (k == extra_last));
      if (k == extra_last - 1) chk("err_before_extra", {31'd0, err}, 32'd0);
      if (k == extra_last) chk("err_after_extra", {31'd0, err}, 32'd1);
      if (gap != 0 && k != nbeats - 1) step(1);
    end
  endtask

  task automatic rd_a(input int b, input int a, output logic [7:0] d);
    rd_en_A[b] = 1'b1; rd_addr_A[b] = a[3:0];
    step(1);
    d = rd_data_A[b];
    rd_en_A[b] = 1'b0;
  endtask

  task automatic rd_b(input int b, input int a, output logic [7:0] d);
    rd_en_B[b] = 1'b1; rd_addr_B[b] = a[3:0];
    step(1);
    d = rd_data_B[b];
    rd_en_B[b] = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    step(1);
    done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tdata = 32'd0; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b0; done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_en_A[i] = 1'b0; rd_addr_A[i] = 4'd0;
      rd_en_B[i] = 1'b0; rd_addr_B[i] = 4'd0;
    end

    step(2);
    chk("rst_tready", {31'd0, tready}, 32'd1);
    chk("rst_start",  {31'd0, start},  32'd0);
    chk("rst_loaded", {31'd0, loaded}, 32'd0);
    chk("rst_err",    {31'd0, err},    32'd0);
    rst = 1'b0;
    step(1);
    chk("post_rst_tready", {31'd0, tready}, 32'd1);
    chk("post_rst_loaded", {31'd0, loaded}, 32'd0);

    // Stream 1: back-to-back, data = k.
    send_stream(0, 0, -1, 128, 1'b0, 32'd0);
    chk("s1_start",  {31'd0, start},  32'd1);
    chk("s1_loaded", {31'd0, loaded}, 32'd1);
    chk("s1_tready", {31'd0, tready}, 32'd0);
    chk("s1_acc",    acc_cnt,         32'd128);
    chk("s1_err",    {31'd0, err},    32'd0);
    step(1);
    chk("s1_start_once", {31'd0, start},  32'd0);
    chk("s1_loaded_lvl", {31'd0, loaded}, 32'd1);
    chk("s1_sm_cnt",     sm_cnt,          32'd1);
    rd_a(2, 5, rd);  chk("s1_a2_5",  {24'd0, rd}, 32'd37);
    rd_b(1, 0, rd);  chk("s1_b1_0",  {24'd0, rd}, 32'd80);
    rd_a(0, 0, rd);  chk("s1_a0_0",  {24'd0, rd}, 32'd0);
    rd_a(3, 15, rd); chk("s1_a3_15", {24'd0, rd}, 32'd63);
    rd_b(3, 15, rd); chk("s1_b3_15", {24'd0, rd}, 32'd127);
    rd_addr_A[2] = 4'd0;
    step(1);
    chk("rd_hold", {24'd0, rd_data_A[2]}, 32'd37);

    // Held tvalid in LOADED must not be accepted or written.
    tvalid = 1'b1; tdata = 32'hEE; tlast = 1'b0;
    step(4);
    chk("hold_tready", {31'd0, tready}, 32'd0);
    chk("hold_acc",    acc_cnt,         32'd128);
    tvalid = 1'b0;
    rd_a(2, 5, rd); chk("hold_a2_5", {24'd0, rd}, 32'd37);
    pulse_done();
    chk("rel_tready", {31'd0, tready}, 32'd1);
    chk("rel_loaded", {31'd0, loaded}, 32'd0);
    pulse_done();
    chk("done_ignored", {31'd0, tready}, 32'd1);

    // Stream 2: data = 255 - k overwrites banks.
    send_stream(1, 0, -1, 128, 1'b0, 32'd0);
    chk("s2_start", {31'd0, start}, 32'd1);
    rd_a(2, 5, rd); chk("s2_a2_5", {24'd0, rd}, 32'hDA);
    rd_b(1, 0, rd); chk("s2_b1_0", {24'd0, rd}, 32'hAF);
    chk("s2_acc", acc_cnt, 32'd256);
    chk("s2_sm_cnt", sm_cnt, 32'd2);
    pulse_done();

    // Stream 3: tvalid every other cycle, stray tlast on beat 60.
    send_stream(0, 1, 60, 128, 1'b0, 32'd0);
    chk("s3_start", {31'd0, start}, 32'd1);
    chk("s3_err",   {31'd0, err},   32'd1);
    chk("s3_acc",   acc_cnt,        32'd384);
    rd_a(2, 5, rd); chk("s3_a2_5", {24'd0, rd}, 32'd37);
    rd_b(1, 0, rd); chk("s3_b1_0", {24'd0, rd}, 32'd80);
    chk("s3_sm_cnt", sm_cnt, 32'd3);
    pulse_done();

    // Reset in the middle of a transfer.
    send_stream(0, 0, -1, 40, 1'b0, 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_tready", {31'd0, tready}, 32'd1);
    chk("mid_rst_loaded", {31'd0, loaded}, 32'd0);
    chk("mid_rst_err",    {31'd0, err},    32'd0);

    send_stream(0, 0, -1, 128, 1'b1, 32'h55);
    chk("s4_start", {31'd0, start}, 32'd1);
    rd_a(0, 0, rd); chk("s4_a0_0", {24'd0, rd}, 32'h55);
    rd_a(0, 1, rd); chk("s4_a0_1", {24'd0, rd}, 32'd1);
    pulse_done();

    // Upper tdata bits are discarded.
    send_stream(0, 0, -1, 128, 1'b1, 32'hABCD1234);
    chk("s5_start", {31'd0, start}, 32'd1);
    chk("s5_err",   {31'd0, err},   32'd0);
    rd_a(0, 0, rd); chk("s5_a0_0", {24'd0, rd}, 32'h34);
    chk("s5_sm_cnt", sm_cnt, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/s2mm.md
S2MM -- requirements
Module: s2mm

Interface
REQ-001 SHALL have parameter M, default 8, giving the matrix dimension (matrices are M x M).
REQ-002 SHALL have parameter N1, default 4, giving the number of A banks; M*M/N1 SHALL be an integer power of two.
REQ-003 SHALL have parameter N2, default 4, giving the number of B banks; M*M/N2 SHALL be an integer power of two.
REQ-004 SHALL have parameter D_W, default 8, giving the element width; D_W <= 32.
REQ-005 SHALL have clk, input, 1: the only clock; all logic is on posedge clk.
REQ-006 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have s_axis_s2mm_tdata, input, 32: stream data; only bits [D_W-1:0] are used.
REQ-008 SHALL have s_axis_s2mm_tkeep, input, 4: ignored.
REQ-009 SHALL have s_axis_s2mm_tlast, input, 1: end-of-transfer marker.
REQ-010 SHALL have s_axis_s2mm_tvalid, input, 1, and s_axis_s2mm_tready, output, 1: the AXI-Stream handshake.
REQ-011 SHALL have rd_en_A [N1], input, 1 each; rd_addr_A [N1], input, clog2(M*M/N1) each; and rd_data_A [N1], output, D_W each: the A-bank read ports.
REQ-012 SHALL have rd_en_B [N2], rd_addr_B [N2] and rd_data_B [N2], with the same shapes as REQ-011 but sized by N2: the B-bank read ports.
REQ-013 SHALL have done_multiply, input, 1: a downstream pulse that releases the buffers.
REQ-014 SHALL have the outputs start_multiply (1, one-cycle pulse), loaded (1, level) and err_tlast (1, sticky).

Function
REQ-015 SHALL accept a beat only when tvalid && tready are both high; beat index k counts 0 to 2*M*M-1.
REQ-016 SHALL treat beats 0 to M*M-1 as A, row-major, element i = k.
REQ-017 SHALL treat beats M*M to 2*M*M-1 as B, with element i = k - M*M.
REQ-018 SHALL write A element i to bank i / (M*M/N1) at address i % (M*M/N1), and B element i the same way using N2.
REQ-019 SHALL write each accepted beat in the same cycle it is accepted; the written data is tdata[D_W-1:0], and upper bits are discarded.
REQ-020 SHALL implement the FSM states RECV_A, RECV_B and LOADED; reset enters RECV_A.
REQ-021 SHALL go from RECV_A to RECV_B on acceptance of beat M*M-1.
REQ-022 SHALL go from RECV_B to LOADED on acceptance of beat 2*M*M-1.
REQ-023 SHALL go from LOADED to RECV_A on done_multiply and clear the beat counter.
REQ-024 SHALL ignore done_multiply in RECV_A and RECV_B.
REQ-025 SHALL drive tready = 1 in RECV_A and RECV_B, and tready = 0 in LOADED; tready SHALL be registered (a state-only function) and SHALL NOT depend combinationally on tvalid.
REQ-026 SHALL assert start_multiply for exactly one cycle, namely the first cycle in LOADED (one cycle after the final beat is accepted).
REQ-027 SHALL hold loaded = 1 throughout LOADED.
REQ-028 SHALL set err_tlast when tlast is 1 on any accepted beat other than 2*M*M-1, or when tlast is 0 on beat 2*M*M-1.
REQ-029 SHALL NOT alter counting or state transitions because of a tlast error; err_tlast SHALL clear only on rst.
REQ-030 SHALL provide 1-cycle read latency: rd_data is valid the cycle after rd_en.
REQ-031 SHALL hold rd_data when rd_en is low.
REQ-032 SHALL allow reads in any state; read contents are guaranteed only in LOADED, and there are no write/read collisions in LOADED.
REQ-033 SHALL have no timeout: a stalled stream (tvalid low) holds state indefinitely.

Reset
REQ-034 SHALL drive, during the rst cycle and the cycle after it: state = RECV_A, beat counter = 0, tready = 1, start_multiply = 0, loaded = 0, err_tlast = 0.
REQ-035 SHALL, when rst is applied mid-transfer, abandon the partial matrix; the next accepted beat is index 0.
REQ-036 SHALL NOT reset memory contents.

Structure
REQ-037 SHALL place the state enum typedef and the localparams for A/B bank depths and address widths in the shared package s2mm_pkg.
REQ-038 SHALL instantiate the existing dual-port memory sub-module mem once per bank (N1+N2 instances), with clkA = clkB = clk, port A used for writes and port B for reads.

Verification (M=8, N1=N2=4, D_W=8)
REQ-039 SHALL cover: 128 beats with tdata = k and tlast on beat 127 -> one start_multiply pulse in the cycle after beat 127; A bank2 addr5 reads 37; B bank1 addr0 reads 80; err_tlast = 0.
REQ-040 SHALL cover: tvalid toggled every other cycle -> identical bank contents to REQ-039 and exactly 128 acceptances.
REQ-041 SHALL cover: tlast also asserted on beat 60 -> err_tlast = 1 from the cycle after beat 60; start_multiply still follows beat 127.
REQ-042 SHALL cover: in LOADED with tvalid held at 1 -> tready = 0 and contents unchanged; a done_multiply pulse -> tready = 1 on the next cycle and a second stream overwrites the banks.
REQ-043 SHALL cover: rst at beat 40 -> tready = 1 and loaded = 0 after reset; a new stream with tdata = 0x55 lands at A bank0 addr0.
REQ-044 SHALL cover: beat 0 with tdata = 0xABCD1234 -> A bank0 addr0 reads 0x34.
